// File: rtl/operand_collector_if.sv
// Stream-to-frame handshake bundle for operand_collector.
// frame_cnt is present only when OPCOL_FRAME_CNT_EN is defined.
interface operand_collector_if #(
  parameter int DATA_W = 32,
  parameter int FCNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] e;
  logic [2:0]        out_cnt;
`ifdef OPCOL_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, a, b, c, d, e, out_cnt
`ifdef OPCOL_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, a, b, c, d, e, out_cnt
`ifdef OPCOL_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/operand_collector.sv
// Packs a serial word stream into a zero-filled 5-slot frame a..e.
// Define OPCOL_FRAME_CNT_EN to add the frame_cnt handoff counter.
module operand_collector #(
  parameter int DATA_W = 32,
  parameter int FCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_collector_if.slave   bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [2:0]                  out_cnt_q, out_cnt_d;
  logic [4:0][DATA_W-1:0]      slot_q, slot_d;
`ifdef OPCOL_FRAME_CNT_EN
  logic [FCNT_W-1:0]           frame_cnt_q, frame_cnt_d;
`endif

  logic accept;
  logic handoff;

  assign accept  = bus.in_valid & (state_q == COLLECT);
  assign handoff = bus.out_ready & (state_q == FULL);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_cnt_d = out_cnt_q;
    slot_d    = slot_q;
`ifdef OPCOL_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int i = 0; i < 5; i++) begin
            if (idx_q == 3'(i)) slot_d[i] = bus.in_data;
          end
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd4 || bus.in_last) begin
            state_d   = FULL;
            out_cnt_d = idx_q + 3'd1;
          end
        end
      end
      FULL: begin
        if (handoff) begin
          state_d   = COLLECT;
          idx_d     = 3'd0;
          out_cnt_d = 3'd0;
          slot_d    = '0;
`ifdef OPCOL_FRAME_CNT_EN
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
`endif
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= 3'd0;
      out_cnt_q <= 3'd0;
      slot_q    <= '0;
`ifdef OPCOL_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_cnt_q <= out_cnt_d;
      slot_q    <= slot_d;
`ifdef OPCOL_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // Handshake flags decode the state directly, never the inputs.
  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == FULL);
  assign bus.a         = slot_q[0];
  assign bus.b         = slot_q[1];
  assign bus.c         = slot_q[2];
  assign bus.d         = slot_q[3];
  assign bus.e         = slot_q[4];
  assign bus.out_cnt   = out_cnt_q;
`ifdef OPCOL_FRAME_CNT_EN
  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Directed + randomized bench for operand_collector against a frame-queue model.
// Define OPCOL_FRAME_CNT_EN to also check frame_cnt with a 2-bit counter.
module tb_operand_collector;

  localparam int DW = 32;
`ifdef OPCOL_FRAME_CNT_EN
  localparam int FW = 2;
`else
  localparam int FW = 16;
`endif

  typedef struct packed {
    logic [4:0][DW-1:0] w;
    logic [2:0]         cnt;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   total_frames = 0;
  bit   rand_rdy = 1'b0;

  frame_t          exp_q[$];
  frame_t          got_q[$];
  logic [DW-1:0]   cur[$];

  operand_collector_if #(.DATA_W(DW), .FCNT_W(FW)) bus ();

  operand_collector #(.DATA_W(DW), .FCNT_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.e, bus.d, bus.c, bus.b, bus.a, bus.out_cnt});
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus.out_ready = ($urandom_range(2) != 0);
    end
  end

  task automatic chk(input string tag, input logic [167:0] got,
                     input logic [167:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] dat, input logic l);
    frame_t f;
    cur.push_back(dat);
    if (l || cur.size() == 5) begin
      f.w = '0;
      foreach (cur[i]) f.w[i] = cur[i];
      f.cnt = 3'(cur.size());
      exp_q.push_back(f);
      total_frames++;
      cur.delete();
    end
  endtask

  task automatic put(input logic [DW-1:0] dat, input logic l);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = dat;
    bus.in_last  = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 168'(acc), 168'(1));
    else model_accept(dat, l);
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic check_frames(input string tag);
    frame_t g, x;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_nframes"}, 168'(got_q.size()), 168'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_slots"}, 168'(g.w), 168'(x.w));
      chk({tag, "_cnt"}, 168'(g.cnt), 168'(x.cnt));
    end
    got_q.delete();
    exp_q.delete();
`ifdef OPCOL_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, 168'(bus.frame_cnt), 168'(FW'(total_frames)));
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 168'(bus.in_ready), 168'(1));
    chk("rst_out_valid", 168'(bus.out_valid), 168'(0));
    chk("rst_a", 168'(bus.a), 168'(0));
    chk("rst_cnt", 168'(bus.out_cnt), 168'(0));

    put(32'd1, 1'b0);
    put(32'd2, 1'b0);
    put(32'd3, 1'b0);
    rst = 1'b1;
    cur.delete();
    #1;
    chk("midrst_out_valid", 168'(bus.out_valid), 168'(0));
    chk("midrst_slots",
        168'({bus.a, bus.b, bus.c, bus.d, bus.e}), 168'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", 168'(bus.in_ready), 168'(1));
    check_frames("midrst");

    for (int i = 1; i <= 5; i++) put(DW'(i), 1'b0);
    chk("full_lat_valid", 168'(bus.out_valid), 168'(1));
    chk("full_in_ready", 168'(bus.in_ready), 168'(0));
    chk("full_slots", 168'({bus.e, bus.d, bus.c, bus.b, bus.a}),
        168'({32'd5, 32'd4, 32'd3, 32'd2, 32'd1}));
    chk("full_cnt", 168'(bus.out_cnt), 168'(5));
    @(posedge clk);
    #1;
    chk("full_valid_1cyc", 168'(bus.out_valid), 168'(0));
    chk("full_clear", 168'({bus.a, bus.e}), 168'(0));
    check_frames("full");

    put(32'hA, 1'b0);
    put(32'hB, 1'b1);
    check_frames("short");

    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) put(DW'(i * 10), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd77;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 168'(bus.out_valid), 168'(1));
      chk("bp_in_ready", 168'(bus.in_ready), 168'(0));
      chk("bp_hold", 168'({bus.a, bus.e, bus.out_cnt}),
          168'({32'd10, 32'd50, 3'd5}));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    put(32'd77, 1'b1);
    check_frames("bp");

    put(32'hFFFF_FFFF, 1'b1);
    for (int i = 6; i <= 10; i++) put(DW'(i), 1'b0);
    check_frames("single");

    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
      put(DW'($urandom), ($urandom_range(3) == 0));
    end
    put(DW'($urandom), 1'b1);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    check_frames("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
